// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-oriented UART transmitter.
// Holds the FSM state encoding, parity mode constants and the parity function.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Unused upper data bits must be zero so they do not disturb the result.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PAR_ODD) begin
            return ~p;
        end else if (mode == PAR_EVEN) begin
            return p;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts system clocks per UART bit and flags the last one.
// Clearing restarts the bit so every state begins on a full bit period.
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_baud_tick: CLK_DIV must be at least 2");
    end

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_word.sv
// UART transmitter sending one multi-character word per valid/ready handshake.
// Characters go out LSB first, back to back, with optional parity and stop bits.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CHARS     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS*CHARS-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         tx,
    output logic                         busy,
    output logic                         done
);

    localparam int WW = DATA_BITS * CHARS;
    localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW = $clog2(BMAX);
    localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] CHR_LAST  = CW'(CHARS - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("uart_tx_word: CLK_DIV must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_word: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
        $error("uart_tx_word: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop
        $error("uart_tx_word: STOP_BITS must be 1..4");
    end
    if (CHARS < 1) begin : g_bad_chars
        $error("uart_tx_word: CHARS must be at least 1");
    end

    uart_state_t          state_q, state_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [CW-1:0]        chr_q, chr_d;
    logic [WW-1:0]        word_q, word_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] char_d;
    logic                 tick;
    logic                 baud_clear;

    assign baud_clear = (state_q == ST_IDLE) || (state_d != state_q);

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            chr_q   <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            chr_q   <= chr_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        chr_d   = chr_q;
        word_d  = word_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_START;
                    word_d  = in_data;
                    bit_d   = '0;
                    chr_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d  = '0;
                        word_d = word_q >> DATA_BITS;
                        if (chr_q == CHR_LAST) begin
                            state_d = ST_IDLE;
                            chr_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_START;
                            chr_d   = chr_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the next state so tx changes on the same edge.
    always_comb begin
        char_d = word_d[DATA_BITS-1:0];
        tx_d   = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = char_d[bit_d];
            ST_PARITY: tx_d = parity_bit(9'(char_d), PARITY);
            default:   tx_d = 1'b1;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = ~in_ready;
    assign tx       = tx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Self-checking bench: three transmitter configurations against a bit-list model.
// Directed scenarios plus randomized handshakes; every cycle is compared.
module tb_uart_tx_word;

    localparam int DIV = 4;
    localparam int HN  = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  tx_w, rdy_w, busy_w, done_w;

    always #5 clk = ~clk;

    uart_tx_word #(
        .CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CHARS(2)
    ) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    uart_tx_word #(
        .CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CHARS(1)
    ) u1 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    uart_tx_word #(
        .CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CHARS(1)
    ) u2 (
        .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit   seq [3][128];
    int   len [3];
    int   pos [3];
    bit   dexp [3];
    int   acc_cyc [3];
    int   acc_cnt [3];
    int   done_cyc [3];
    bit   hist [3][HN];
    logic [2:0] rdy_prev = '0;

    function automatic int ch_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int par_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int sb_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected line level for every clock of one word, from the framing rules.
    function automatic void build(input int i, input logic [15:0] w);
        int n;
        int fl;
        int ones;
        logic [7:0] ch;
        bit frame [16];
        n = 0;
        for (int c = 0; c < ch_of(i); c++) begin
            ch = w[c*8 +: 8];
            ones = $countones(ch);
            fl = 0;
            frame[fl++] = 1'b0;
            for (int b = 0; b < 8; b++) frame[fl++] = ch[b];
            if (par_of(i) == 1) frame[fl++] = (ones % 2 == 0);
            if (par_of(i) == 2) frame[fl++] = (ones % 2 == 1);
            for (int s = 0; s < sb_of(i); s++) frame[fl++] = 1'b1;
            for (int k = 0; k < fl; k++) begin
                for (int r = 0; r < DIV; r++) seq[i][n++] = frame[k];
            end
        end
        len[i] = n;
        pos[i] = 0;
    endfunction

    initial begin
        bit bm;
        int ex;
        for (int i = 0; i < 3; i++) begin
            len[i] = 0; pos[i] = 0; dexp[i] = 0;
            acc_cyc[i] = 0; acc_cnt[i] = 0; done_cyc[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (in_valid && rdy_prev[i] && !rst) begin
                    acc_cyc[i] = cyc;
                    acc_cnt[i]++;
                end
                if (rst) begin
                    len[i] = 0; pos[i] = 0; dexp[i] = 0;
                end else if (pos[i] < len[i]) begin
                    pos[i]++;
                    dexp[i] = (pos[i] == len[i]);
                end else begin
                    dexp[i] = 0;
                    if (in_valid) build(i, in_data);
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                bm = (pos[i] < len[i]);
                ex = bm ? int'(seq[i][pos[i]]) : 1;
                chk($sformatf("u%0d_tx", i), int'(tx_w[i]), ex);
                chk($sformatf("u%0d_ready", i), int'(rdy_w[i]), int'(!bm));
                chk($sformatf("u%0d_busy", i), int'(busy_w[i]), int'(bm));
                chk($sformatf("u%0d_done", i), int'(done_w[i]), int'(dexp[i]));
                if (cyc < HN) hist[i][cyc] = tx_w[i];
                if (done_w[i]) done_cyc[i] = cyc;
            end
            rdy_prev = rdy_w;
        end
    end

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdy_w != 3'b111 && n < maxc);
        if (rdy_w != 3'b111) chk("idle_timeout", int'(rdy_w), 7);
    endtask

    task automatic wait_acc(input int target, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (acc_cnt[0] < target && n < maxc);
        if (acc_cnt[0] < target) chk("accept_timeout", acc_cnt[0], target);
    endtask

    task automatic send(input logic [15:0] w, output int a);
        wait_idle(300);
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = acc_cyc[0];
    endtask

    // Samples the middle of each bit of a 2-character 8N1 word on u0.
    task automatic check_word(input string nm, input int a, input logic [15:0] exp);
        logic [15:0] got;
        int fr;
        got = '0;
        fr = 0;
        for (int c = 0; c < 2; c++) begin
            for (int b = 0; b < 8; b++) begin
                got[c*8+b] = hist[0][a + (c*10 + 1 + b)*DIV + 2];
            end
            if (hist[0][a + (c*10)*DIV + 2] != 1'b0) fr++;
            if (hist[0][a + (c*10 + 9)*DIV + 2] != 1'b1) fr++;
        end
        chk({nm, "_data"}, int'(got), int'(exp));
        chk({nm, "_framing"}, fr, 0);
    endtask

    initial begin
        int a;
        int a1;
        int a2;
        int n0;
        int lows;
        int hold;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", int'(tx_w[0]), 1);
        chk("rst_ready", int'(rdy_w[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_done", int'(done_w[0]), 0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_w != 3'b111) lows++;
        end
        chk("idle_100", lows, 0);

        send(16'h1234, a);
        repeat (85) @(negedge clk);
        check_word("w1234", a, 16'h1234);
        chk("w1234_done_lat", done_cyc[0] - a, 80);
        chk("model_len_8n1", len[0], 80);

        send(16'h00A5, a);
        repeat (55) @(negedge clk);
        chk("par_even_bit", int'(hist[1][a + 38]), 0);
        chk("par_odd_bit", int'(hist[2][a + 38]), 1);
        chk("lat_even_1stop", done_cyc[1] - a, 44);
        chk("lat_odd_2stop", done_cyc[2] - a, 48);
        chk("stop2_high", int'(hist[2][a + 45]), 1);

        wait_idle(300);
        n0 = acc_cnt[0];
        in_data  = 16'h00FF;
        in_valid = 1'b1;
        wait_acc(n0 + 1, 50);
        a1 = acc_cyc[0];
        in_data = 16'hFF00;
        wait_acc(n0 + 2, 200);
        a2 = acc_cyc[0];
        in_valid = 1'b0;
        repeat (85) @(negedge clk);
        chk("b2b_gap", a2 - a1, 81);
        chk("b2b_idle_clk", int'(hist[0][a1 + 80]), 1);
        chk("b2b_start", int'(hist[0][a2]), 0);
        chk("b2b_char_join", int'(hist[0][a1 + 40]), 0);
        check_word("w00ff", a1, 16'h00FF);
        check_word("wff00", a2, 16'hFF00);

        send(16'hBEEF, a);
        n0 = acc_cnt[0];
        repeat (60) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
        end
        in_valid = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_extra_accept", acc_cnt[0] - n0, 0);
        check_word("wbeef", a, 16'hBEEF);

        send(16'hA5F0, a);
        while (cyc < a + 17) @(negedge clk);
        chk("pre_rst_bit3", int'(tx_w[0]), 0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", int'(tx_w), 7);
        chk("rst_async_busy", int'(busy_w), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_ready", int'(rdy_w[0]), 1);
        send(16'h5555, a);
        repeat (85) @(negedge clk);
        check_word("w5555", a, 16'h5555);
        chk("w5555_done_lat", done_cyc[0] - a, 80);

        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            hold = $urandom_range(1, 120);
            repeat (hold) begin
                in_data = 16'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        repeat (120) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
